// File: rtl/polaris_stage_f_if.sv
// Fetch-stage bus bundle: F-bus instruction fetch handshake plus the M-bus cycle request.
// The master side is the fetch stage; the slave side is the memory subsystem.
interface polaris_stage_f_if;
    logic        f_cyc_o;
    logic        f_ack_i;
    logic [63:2] f_adr_o;
    logic        m_cyc_o;

    modport master (
        output f_cyc_o,
        output f_adr_o,
        output m_cyc_o,
        input  f_ack_i
    );

    modport slave (
        input  f_cyc_o,
        input  f_adr_o,
        input  m_cyc_o,
        output f_ack_i
    );
endinterface

// File: rtl/polaris_stage_f.sv
// Polaris instruction-fetch stage: owns the PC and streams word-aligned fetches on the F-bus,
// advancing one word per acknowledged cycle. Data cycles are never requested from here.
module polaris_stage_f #(
    parameter logic [63:0] RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00
) (
    input  logic               clk_i,
    input  logic               reset_i,
    polaris_stage_f_if.master  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:2] pc_q, pc_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR[63:2];
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Acks only count once a cycle is actually on the bus, so the edge leaving IDLE never advances.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (bus.f_ack_i) pc_d = pc_q + 62'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.f_cyc_o = (state_q == FETCH);
    assign bus.f_adr_o = pc_q;
    assign bus.m_cyc_o = 1'b0;

endmodule

// File: tb/tb_polaris_stage_f.sv
// Directed bench for polaris_stage_f: reset hold, first fetch, wait states, async reset, and a
// 70-edge stream that wraps the byte address through zero.
module tb_polaris_stage_f;
    logic clk;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    logic [63:0] exp_adr;

    polaris_stage_f_if bus ();

    polaris_stage_f #(.RESET_VECTOR(64'hFFFF_FFFF_FFFF_FF00)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Sample all outputs; m_cyc_o must be idle at every sample.
    task automatic sample(input string tag, input logic exp_cyc, input logic [63:0] exp_byte);
        chk({tag, " f_cyc"}, {63'd0, bus.f_cyc_o}, {63'd0, exp_cyc});
        chk({tag, " f_adr"}, {bus.f_adr_o, 2'b00}, exp_byte);
        chk({tag, " m_cyc"}, {63'd0, bus.m_cyc_o}, 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        bus.f_ack_i = 1'b1;
        #1;
        sample("reset_async", 1'b0, 64'hFFFF_FFFF_FFFF_FF00);
        tick();
        sample("reset_hold", 1'b0, 64'hFFFF_FFFF_FFFF_FF00);

        // First fetch: the edge leaving IDLE must not consume the ack.
        rst = 1'b0;
        tick();
        sample("first_fetch", 1'b1, 64'hFFFF_FFFF_FFFF_FF00);
        tick();
        sample("second_fetch", 1'b1, 64'hFFFF_FFFF_FFFF_FF04);

        bus.f_ack_i = 1'b0;
        tick();
        sample("wait1", 1'b1, 64'hFFFF_FFFF_FFFF_FF04);
        tick();
        sample("wait2", 1'b1, 64'hFFFF_FFFF_FFFF_FF04);
        bus.f_ack_i = 1'b1;
        tick();
        sample("after_wait", 1'b1, 64'hFFFF_FFFF_FFFF_FF08);
        tick();
        sample("adv_0c", 1'b1, 64'hFFFF_FFFF_FFFF_FF0C);
        tick();
        sample("adv_10", 1'b1, 64'hFFFF_FFFF_FFFF_FF10);

        // Reset between edges must take effect without a clock.
        #3;
        rst = 1'b1;
        #1;
        sample("async_reset", 1'b0, 64'hFFFF_FFFF_FFFF_FF00);
        tick();
        sample("async_reset_hold", 1'b0, 64'hFFFF_FFFF_FFFF_FF00);

        // Streaming from reset with ack held high for 70 edges.
        rst     = 1'b0;
        exp_adr = 64'hFFFF_FFFF_FFFF_FF00;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k > 1) exp_adr = exp_adr + 64'd4;
            sample($sformatf("stream%0d", k), 1'b1, exp_adr);
            if (k == 64) chk("wrap_pre",  {bus.f_adr_o, 2'b00}, 64'hFFFF_FFFF_FFFF_FFFC);
            if (k == 65) chk("wrap_zero", {bus.f_adr_o, 2'b00}, 64'h0000_0000_0000_0000);
            if (k == 66) chk("wrap_post", {bus.f_adr_o, 2'b00}, 64'h0000_0000_0000_0004);
        end
        chk("stream_end", {bus.f_adr_o, 2'b00}, 64'h0000_0000_0000_0014);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
